// File: rtl/input_debounce_sync.sv
// Two-flop synchroniser plus counter-based debounce FSM for one raw asynchronous input.
// Define DEBOUNCE_EDGE_OUT_EN to generate the registered rise/fall pulses; otherwise they are tied low.
module input_debounce_sync #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CntTarget = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic       sync1_q;
  logic       s_q;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       dout_q, dout_d;
  logic       busy_q, busy_d;
  logic       rise_d, fall_d;

  // Only s_q is ever seen by the FSM; sync1_q may go metastable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= din;
      s_q     <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CntOne;
        end
      end
      WAIT_HIGH: begin
        if (!s_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntTarget) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      IDLE_HIGH: begin
        if (!s_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CntOne;
        end
      end
      WAIT_LOW: begin
        if (s_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntTarget) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_OUT_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  logic unusedEdges;
  assign unusedEdges = rise_d ^ fall_d;
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
